// File: rtl/switch_port_pkg.sv
// Shared definitions for the switch input port: register offsets,
// status bit positions and the debounce state encoding.
package switch_port_pkg;

    localparam logic [1:0] SW_VALUE  = 2'b00;
    localparam logic [1:0] SW_STATUS = 2'b10;

    localparam int ST_CHANGED  = 0;
    localparam int ST_OVERFLOW = 1;

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } deb_state_e;

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchroniser plus vector-wide debouncer; publishes the accepted
// switch vector and a single-cycle pulse whenever it changes value.
module switch_debounce
    import switch_port_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] switches,
    output logic [WIDTH-1:0] stable,
    output logic             update
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    deb_state_e       state_q, state_d;
    logic             update_d;

    always_comb begin
        sync1_d  = switches;
        sync2_d  = sync1_q;
        cand_d   = cand_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        state_d  = state_q;
        update_d = 1'b0;
        case (state_q)
            STABLE: begin
                if (sync2_q != cand_q) begin
                    cand_d  = sync2_q;
                    cnt_d   = '0;
                    state_d = SETTLING;
                end
            end
            SETTLING: begin
                if (sync2_q != cand_q) begin
                    cand_d = sync2_q;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // A glitch that settled back to the old value ends here silently.
                    state_d = STABLE;
                    if (cand_q != stable_q) begin
                        stable_d = cand_q;
                        update_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = STABLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            state_q  <= STABLE;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
        end
    end

    assign stable = stable_q;
    assign update = update_d;

endmodule

// File: rtl/switch_port.sv
// CPU-facing switch peripheral: sticky change/overflow status with
// read-to-clear, and a one-cycle-latency registered read port.
module switch_port
    import switch_port_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] switches,
    input  logic             ior,
    input  logic             switchcs,
    input  logic [1:0]       swaddr,
    output logic [WIDTH-1:0] ioread_data,
    output logic             read_valid,
    output logic             change_pending
);

    logic [WIDTH-1:0] stable;
    logic             update;

    logic             changed_q, changed_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             rd_en;
    logic             status_rd;

    switch_debounce #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock   (clock),
        .reset   (reset),
        .switches(switches),
        .stable  (stable),
        .update  (update)
    );

    always_comb begin
        rd_en      = ior && switchcs;
        status_rd  = rd_en && (swaddr == SW_STATUS);
        changed_d  = changed_q;
        overflow_d = overflow_q;
        if (update) begin
            changed_d = 1'b1;
            if (changed_q) overflow_d = 1'b1;
        end
        // Read-to-clear: clear beats set for overflow, a fresh update keeps changed.
        if (status_rd) begin
            overflow_d = 1'b0;
            changed_d  = update;
        end

        rdata_d  = '0;
        rvalid_d = rd_en;
        if (rd_en) begin
            case (swaddr)
                SW_VALUE: rdata_d = stable;
                SW_STATUS: begin
                    rdata_d[ST_CHANGED]  = changed_q;
                    rdata_d[ST_OVERFLOW] = overflow_q;
                end
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            changed_q  <= 1'b0;
            overflow_q <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            changed_q  <= changed_d;
            overflow_q <= overflow_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign ioread_data    = rdata_q;
    assign read_valid     = rvalid_q;
    assign change_pending = changed_q;

endmodule

// File: tb/tb_switch_port.sv
// Bench for switch_port with a short debounce window: a run-length model of
// the switch path checked every cycle, plus hand-computed directed expectations.
module tb_switch_port;
    import switch_port_pkg::*;

    localparam int W = 16;
    localparam int N = 4;

    logic         clock    = 1'b0;
    logic         reset    = 1'b1;
    logic [W-1:0] switches = '0;
    logic         ior      = 1'b0;
    logic         switchcs = 1'b0;
    logic [1:0]   swaddr   = 2'b00;
    logic [W-1:0] ioread_data;
    logic         read_valid;
    logic         change_pending;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    switch_port #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .switches      (switches),
        .ior           (ior),
        .switchcs      (switchcs),
        .swaddr        (swaddr),
        .ioread_data   (ioread_data),
        .read_valid    (read_valid),
        .change_pending(change_pending)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: synchroniser as a two-deep delay; acceptance when the synced
    // value has been seen on N+1 consecutive edges following a change.
    logic [W-1:0] m_s1 = '0, m_s2 = '0, m_prev = '0, m_stable = '0, m_rd = '0;
    int           m_run = 0;
    bit           m_armed = 0, m_changed = 0, m_ovf = 0, m_rv = 0, m_live = 0;

    always @(posedge clock) begin : model
        logic [W-1:0] sv;
        bit ev, st;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_prev = '0; m_stable = '0; m_rd = '0;
            m_run = 0; m_armed = 0; m_changed = 0; m_ovf = 0; m_rv = 0;
            m_live = 1;
        end else begin
            sv = m_s2;
            ev = 0;
            if (sv != m_prev) begin
                m_prev = sv; m_run = 1; m_armed = 1;
            end else begin
                m_run++;
            end
            if (m_armed && m_run == N + 1) begin
                m_armed = 0;
                ev = (sv != m_stable);
            end
            m_rv = ior && switchcs;
            m_rd = '0;
            if (m_rv && swaddr == 2'b00) m_rd = m_stable;
            else if (m_rv && swaddr == 2'b10) m_rd = {14'b0, m_ovf, m_changed};
            st = m_rv && swaddr == 2'b10;
            if (ev) begin
                m_ovf     = m_ovf | m_changed;
                m_changed = 1;
                m_stable  = sv;
            end
            if (st) begin
                m_ovf     = 0;
                m_changed = ev;
            end
            m_s2 = m_s1;
            m_s1 = switches;
        end
    end

    always @(negedge clock) begin
        if (m_live) begin
            chk("model_rdata", ioread_data, m_rd);
            chk("model_rvalid", W'(read_valid), W'(m_rv));
            chk("model_pending", W'(change_pending), W'(m_changed));
        end
    end

    // Called at a negedge; the read is sampled on the next posedge.
    task automatic rd(input logic [1:0] a, output logic [W-1:0] d);
        ior = 1'b1; switchcs = 1'b1; swaddr = a;
        @(negedge clock);
        ior = 1'b0; switchcs = 1'b0; swaddr = 2'b00;
        d = ioread_data;
        chk("rd_valid", W'(read_valid), W'(1'b1));
    endtask

    initial begin
        logic [W-1:0] r;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("reset_rdata", ioread_data, 16'h0000);
        chk("reset_rvalid", W'(read_valid), W'(1'b0));
        chk("reset_pending", W'(change_pending), W'(1'b0));
        rd(SW_VALUE, r);
        chk("idle_value", r, 16'h0000);

        // Glitch held for three synced cycles, then released
        switches = 16'h0001;
        repeat (3) @(negedge clock);
        switches = 16'h0000;
        repeat (10) @(negedge clock);
        chk("glitch_pending", W'(change_pending), W'(1'b0));
        rd(SW_VALUE, r);
        chk("glitch_value", r, 16'h0000);

        // Clean step: pending must rise exactly 7 cycles after the step
        switches = 16'hA5A5;
        repeat (6) @(negedge clock);
        chk("step_pending_early", W'(change_pending), W'(1'b0));
        @(negedge clock);
        chk("step_pending_on_time", W'(change_pending), W'(1'b1));
        rd(SW_VALUE, r);
        chk("step_value", r, 16'hA5A5);
        rd(SW_STATUS, r);
        chk("step_status", r, 16'h0001);
        rd(SW_STATUS, r);
        chk("step_status_cleared", r, 16'h0000);

        // Two settled changes without a status read
        switches = 16'h0001;
        repeat (10) @(negedge clock);
        switches = 16'h0003;
        repeat (10) @(negedge clock);
        rd(SW_STATUS, r);
        chk("ovf_status", r, 16'h0003);
        rd(SW_STATUS, r);
        chk("ovf_status_cleared", r, 16'h0000);
        rd(SW_VALUE, r);
        chk("ovf_value", r, 16'h0003);

        // Status read sampled on the exact update edge
        switches = 16'h0007;
        repeat (6) @(negedge clock);
        rd(SW_STATUS, r);
        chk("collide_status", r, 16'h0000);
        chk("collide_pending", W'(change_pending), W'(1'b1));
        rd(SW_STATUS, r);
        chk("collide_status_next", r, 16'h0001);

        // Reset while settling
        switches = 16'h00FF;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_rdata", ioread_data, 16'h0000);
        chk("midrst_rvalid", W'(read_valid), W'(1'b0));
        chk("midrst_pending", W'(change_pending), W'(1'b0));
        repeat (6) @(negedge clock);
        chk("midrst_pending_early", W'(change_pending), W'(1'b0));
        @(negedge clock);
        chk("midrst_pending_on_time", W'(change_pending), W'(1'b1));
        rd(2'b01, r);
        chk("reserved_read", r, 16'h0000);
        rd(SW_VALUE, r);
        chk("midrst_value", r, 16'h00FF);

        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
